// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle control unit: state codes, opcodes and
// the mux/ALU select values driven by the output decode.
package mc_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned CNT_W   = 32;
    localparam int unsigned SEL_W   = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_FETCH   = 4'd0,
        ST_DECODE  = 4'd1,
        ST_MEMADR  = 4'd2,
        ST_MEMRD   = 4'd3,
        ST_MEMWB   = 4'd4,
        ST_MEMWR   = 4'd5,
        ST_EXEC    = 4'd6,
        ST_RTYPEWB = 4'd7,
        ST_BRANCH  = 4'd8,
        ST_JUMP    = 4'd9,
        ST_ADDIEX  = 4'd10,
        ST_ADDIWB  = 4'd11,
        ST_HALT    = 4'd12
    } state_e;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

    localparam logic [SEL_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [SEL_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [SEL_W-1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [SEL_W-1:0] SRCB_B      = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_FOUR   = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_IMM    = 2'b10;
    localparam logic [SEL_W-1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
    localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

    // True for the last state of every instruction that retires.
    function automatic logic ends_instr(input state_e s);
        return (s == ST_MEMWB)   || (s == ST_MEMWR)  || (s == ST_RTYPEWB) ||
               (s == ST_ADDIWB)  || (s == ST_BRANCH) || (s == ST_JUMP);
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Moore output decode for the multicycle controller; only FETCH (run) and
// BRANCH (zero) look at anything besides the current state.
module mc_ctrl_decode
    import mc_pkg::*;
(
    input  logic [3:0] state,
    input  logic       run,
    input  logic       zero,
    output logic       PCwe,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource
);

    always_comb begin
        PCwe     = 1'b0;
        IorD     = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = SRCB_B;
        ALUOp    = ALUOP_ADD;
        PCSource = PCSRC_ALU;
        case (state)
            ST_FETCH: begin
                if (run) begin
                    IRWrite = 1'b1;
                    PCwe    = 1'b1;
                    ALUSrcB = SRCB_FOUR;
                end
            end
            ST_DECODE: ALUSrcB = SRCB_IMMSH2;
            ST_MEMADR, ST_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            ST_MEMRD: IorD = 1'b1;
            ST_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            ST_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            ST_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_FUNCT;
            end
            ST_RTYPEWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            ST_ADDIWB: RegWrite = 1'b1;
            // Branch compare and conditional PC load share one cycle.
            ST_BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUOp    = ALUOP_SUB;
                PCSource = PCSRC_ALUOUT;
                PCwe     = zero;
            end
            ST_JUMP: begin
                PCSource = PCSRC_JUMP;
                PCwe     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS-style control unit: state register, next-state logic and a
// retired-instruction counter; control outputs come from mc_ctrl_decode.
module mc_control
    import mc_pkg::*;
#(
    parameter bit HALT_ON_UNKNOWN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [5:0]  op,
    input  logic        zero,
    output logic        PCwe,
    output logic        IorD,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegDst,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUOp,
    output logic [1:0]  PCSource,
    output logic [3:0]  state,
    output logic [31:0] instr_cnt
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  instr_cnt_q, instr_cnt_d;

    always_comb begin
        state_d = ST_FETCH;
        case (state_q)
            ST_FETCH:  state_d = run ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = ST_MEMADR;
                    OP_RTYPE:     state_d = ST_EXEC;
                    OP_BEQ:       state_d = ST_BRANCH;
                    OP_J:         state_d = ST_JUMP;
                    OP_ADDI:      state_d = ST_ADDIEX;
                    default:      state_d = HALT_ON_UNKNOWN ? ST_HALT : ST_FETCH;
                endcase
            end
            ST_MEMADR: state_d = (op == OP_LW) ? ST_MEMRD : ST_MEMWR;
            ST_MEMRD:  state_d = ST_MEMWB;
            ST_EXEC:   state_d = ST_RTYPEWB;
            ST_ADDIEX: state_d = ST_ADDIWB;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_FETCH;
        endcase
    end

    // Count each instruction as it retires back into FETCH; wraps at 2^32.
    always_comb begin
        instr_cnt_d = instr_cnt_q;
        if (ends_instr(state_q)) begin
            instr_cnt_d = instr_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_FETCH;
            instr_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign state     = state_q;
    assign instr_cnt = instr_cnt_q;

    mc_ctrl_decode u_decode (
        .state    (state_q),
        .run      (run),
        .zero     (zero),
        .PCwe     (PCwe),
        .IorD     (IorD),
        .MemWrite (MemWrite),
        .IRWrite  (IRWrite),
        .RegDst   (RegDst),
        .MemtoReg (MemtoReg),
        .RegWrite (RegWrite),
        .ALUSrcA  (ALUSrcA),
        .ALUSrcB  (ALUSrcB),
        .ALUOp    (ALUOp),
        .PCSource (PCSource)
    );

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 Parameter: HALT_ON_UNKNOWN, default 1, meaning unknown opcode enters HALT (1) or returns to FETCH (0).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 run  input  1  fetch permission from debug unit; 0 holds the FSM in FETCH.
REQ-005 op  input  6  opcode field from instruction register; valid from DECODE onward.
REQ-006 zero  input  1  ALU zero flag.
REQ-007 PCwe  output  1  PC write enable.
REQ-008 IorD  output  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-009 MemWrite  output  1  memory write enable.
REQ-010 IRWrite  output  1  instruction register load enable.
REQ-011 RegDst  output  1  write register select: 0 = rt, 1 = rd.
REQ-012 MemtoReg  output  1  write-back data select: 0 = ALUOut, 1 = MDR.
REQ-013 RegWrite  output  1  register file write enable.
REQ-014 ALUSrcA  output  1  ALU A select: 0 = PC, 1 = A.
REQ-015 ALUSrcB  output  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = imm<<2.
REQ-016 ALUOp  output  2  00 = add, 01 = sub, 10 = use funct.
REQ-017 PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-018 state  output  4  current state encoding, for debug display.
REQ-019 instr_cnt  output  32  count of completed instructions.

Function
REQ-020 Moore FSM with 4-bit encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RTYPEWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11, HALT=12; codes 13-15 go to FETCH on the next edge, all outputs 0.
REQ-021 FETCH with run=1: IRWrite=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, PCwe=1; next state DECODE.
REQ-022 FETCH with run=0: every write enable (PCwe, IRWrite, MemWrite, RegWrite) is 0; state stays FETCH.
REQ-023 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00.
REQ-024 DECODE next state by op: 100011/101011 -> MEMADR; 000000 -> EXEC; 000100 -> BRANCH; 000010 -> JUMP; 001000 -> ADDIEX; any other -> HALT if HALT_ON_UNKNOWN=1, else FETCH.
REQ-025 MEMADR and ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00; MEMADR goes to MEMRD if op=100011, else MEMWR; ADDIEX goes to ADDIWB.
REQ-026 MEMRD: IorD=1; next state MEMWB.
REQ-027 MEMWB: RegDst=0, MemtoReg=1, RegWrite=1; next state FETCH.
REQ-028 MEMWR: IorD=1, MemWrite=1; next state FETCH.
REQ-029 EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10; next state RTYPEWB.
REQ-030 RTYPEWB: RegDst=1, MemtoReg=0, RegWrite=1; next state FETCH.
REQ-031 ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1; next state FETCH.
REQ-032 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01, PCwe=zero (combinational in the same cycle); next state FETCH.
REQ-033 JUMP: PCSource=10, PCwe=1; next state FETCH.
REQ-034 HALT: all write enables 0; the FSM stays in HALT until reset, regardless of run.
REQ-035 Any output not listed for a state is 0.
REQ-036 instr_cnt increments by 1 on each transition into FETCH from MEMWB, MEMWR, RTYPEWB, ADDIWB, BRANCH or JUMP; it wraps from FFFFFFFF to 0.
REQ-037 Instruction latencies from FETCH to FETCH: lw 5 cycles; sw, R-type and addi 4 cycles; beq and j 3 cycles.

Reset
REQ-038 On a rising clk edge with rst=0: state=FETCH and instr_cnt=0; this takes priority over any transition, including mid-instruction and HALT.
REQ-039 After reset, outputs are the FETCH decode qualified by run.

Structure
REQ-040 State codes, opcode constants and ALUOp/ALUSrcB/PCSource encodings live in the shared package mc_pkg.
REQ-041 The design is a single state register plus next-state logic; the output decode is the sub-module mc_ctrl_decode (state, run, zero -> control outputs), purely combinational.

Verification
REQ-042 Reset with run=1, op=100011: states 0,1,2,3,4,0; RegWrite=1 only in state 4; instr_cnt=1.
REQ-043 op=000100 with zero=0, then again with zero=1: in BRANCH, PCwe=0 then 1; PCSource=01 both times; each instruction takes 3 cycles.
REQ-044 run=0 for 10 cycles after reset: state=0, PCwe=IRWrite=0 throughout; raise run -> DECODE on the next edge.
REQ-045 op=111111 with HALT_ON_UNKNOWN=1: enters HALT (12) and stays with run=1 for 20 cycles; reset returns to FETCH, instr_cnt=0.
REQ-046 rst=0 asserted in MEMWR: the next state is FETCH, MemWrite=0, instr_cnt=0.
REQ-047 Force instr_cnt=FFFFFFFF, complete a j instruction: instr_cnt=00000000.
